trace_tagger: RTL and testbench
===============================

Name: trace_tagger

Overview:
- Producer side of the pipeline trace/Konata interface.
- Assigns a monotonically increasing sequence ID to every instruction accepted into the I stage and tracks its occupancy through the I, X and M stages.
- Emits one-cycle stage-entry, retire and kill events with matching IDs, which the trace logger consumes.
- Sits beside the core pipeline and takes only the core's fetch, stall and flush controls; it never back-pressures the core.

Parameters:
- ID_W, 32: width of sequence IDs and of the retire counter; IDs wrap modulo 2^ID_W.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_v  in  1  an instruction is presented to the I stage this cycle
- stall  in  1  hold the I and X stages; M receives a bubble
- flush  in  1  taken branch/jump in X; kill the I-stage instruction
- inst_v_i  out  1  an instruction entered I at the last edge
- ci  out  ID_W  ID of that instruction
- inst_v_x  out  1  an instruction entered X at the last edge
- cx  out  ID_W  ID of that instruction
- inst_v_m  out  1  an instruction entered M at the last edge
- cm  out  ID_W  ID of that instruction
- inst_v_r  out  1  an instruction retired from M at the last edge
- cr  out  ID_W  ID of that instruction
- inst_k  out  1  an instruction was killed from I at the last edge
- ck  out  ID_W  ID of that instruction
- retire_cnt  out  ID_W  total retired instructions, wrapping

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valids clear; the next-ID counter and retire_cnt go to 0.
  - All outputs are 0.
  - Asserting reset mid-operation discards in-flight instructions with no kill or retire events.
  - The first edge after reset deassertion uses normal rules.
- State:
  - Per stage, valid bit plus ID: v_i/id_i, v_x/id_x, v_m/id_m.
  - Next-ID counter nid.
- Every output is registered. An event output is high for exactly one cycle, the cycle after the edge at which its transition happened. The ID output is valid only while its strobe is high and holds its last value otherwise.
- Per rising edge, the following apply in parallel and are all computed from pre-edge state.
- M stage (never stalls):
  - If v_m: retire, giving inst_v_r=1, cr=id_m, retire_cnt+1.
  - M then loads X (v_x, id_x) if !stall or flush; otherwise M loads a bubble.
  - inst_v_m=1, cm=id_x when a valid instruction moves X->M.
- X stage:
  - flush: X gets a bubble. The instruction in X (the branch) still moves to M per the rule above.
  - stall (and !flush): X holds, with no event.
  - Otherwise X loads I; inst_v_x=1, cx=id_i when v_i.
- I stage:
  - flush: if v_i, kill it (inst_k=1, ck=id_i). I clears. fetch_v is ignored and no ID is consumed.
  - stall (and !flush): I holds. fetch_v is ignored and no ID is consumed.
  - Otherwise, if fetch_v: I loads nid, with inst_v_i=1, ci=nid, and nid+1. If !fetch_v, I clears.
- Priority: flush overrides stall.
- Retire and kill may occur in the same cycle. Entry events for I, X and M may all assert in the same cycle.
- Wrap: nid and retire_cnt wrap from 2^ID_W-1 to 0 with no flag.
- Latency: an instruction with an unstalled fetch at edge n gives I at n+1, X at n+2, M at n+3 and retire strobe at n+4, each strobe visible the cycle after its edge.
- Invariant: each ID receives exactly one I event, then either one kill or the sequence X, M, R. IDs retire in strictly increasing order.

Test Plan:
- Reset, then fetch_v=1 for 3 cycles with no stall or flush:
  - ci=0,1,2 on consecutive cycles.
  - cx lags ci by 1 cycle, cm by 2, cr by 3.
  - retire_cnt=3 after drain.
- Stall held 2 cycles with ID 1 in I and ID 0 in X:
  - No inst_v_i or inst_v_x during the stall.
  - M takes bubbles and inst_v_m stays 0 for 2 cycles.
  - After release, cx=1 and cm=0.
- Flush with ID 4 in X and ID 5 in I, fetch_v=1 on that same edge:
  - inst_k=1, ck=5.
  - cm=4 on the next cycle.
  - No ID consumed by the ignored fetch; the next accepted fetch gets ci=6.
- flush and stall together:
  - Flush behaviour as above.
  - X->M move of the branch still occurs with inst_v_m=1.
- Assert reset with 3 instructions in flight:
  - All outputs 0 immediately (asynchronous).
  - No retire for in-flight IDs.
  - First fetch after reset gives ci=0.
- With ID_W=4, 17 back-to-back fetches:
  - ci sequence 0..15, 0.
  - retire_cnt wraps to 1 after all 17 retire.

Source files
------------

// File: rtl/trace_tagger.sv
// Trace tagger: assigns sequence IDs to instructions entering I and follows them through
// X and M, emitting registered one-cycle stage-entry, retire and kill events for the logger.
module trace_tagger #(
    parameter int unsigned ID_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_v,
    input  logic            stall,
    input  logic            flush,
    output logic            inst_v_i,
    output logic [ID_W-1:0] ci,
    output logic            inst_v_x,
    output logic [ID_W-1:0] cx,
    output logic            inst_v_m,
    output logic [ID_W-1:0] cm,
    output logic            inst_v_r,
    output logic [ID_W-1:0] cr,
    output logic            inst_k,
    output logic [ID_W-1:0] ck,
    output logic [ID_W-1:0] retire_cnt
);

    // Pipeline occupancy shadow
    logic            v_i_q, v_i_d;
    logic [ID_W-1:0] id_i_q, id_i_d;
    logic            v_x_q, v_x_d;
    logic [ID_W-1:0] id_x_q, id_x_d;
    logic            v_m_q, v_m_d;
    logic [ID_W-1:0] id_m_q, id_m_d;
    logic [ID_W-1:0] nid_q, nid_d;
    logic [ID_W-1:0] retire_cnt_q, retire_cnt_d;

    // Registered event outputs
    logic            inst_v_i_q, inst_v_i_d;
    logic [ID_W-1:0] ci_q, ci_d;
    logic            inst_v_x_q, inst_v_x_d;
    logic [ID_W-1:0] cx_q, cx_d;
    logic            inst_v_m_q, inst_v_m_d;
    logic [ID_W-1:0] cm_q, cm_d;
    logic            inst_v_r_q, inst_v_r_d;
    logic [ID_W-1:0] cr_q, cr_d;
    logic            inst_k_q, inst_k_d;
    logic [ID_W-1:0] ck_q, ck_d;

    logic            x_to_m;

    // A flush never blocks the branch in X from moving on, even under stall.
    assign x_to_m = v_x_q && (!stall || flush);

    always_comb begin
        v_i_d        = v_i_q;
        id_i_d       = id_i_q;
        v_x_d        = v_x_q;
        id_x_d       = id_x_q;
        v_m_d        = x_to_m;
        id_m_d       = id_m_q;
        nid_d        = nid_q;
        retire_cnt_d = retire_cnt_q;

        inst_v_i_d   = 1'b0;
        ci_d         = ci_q;
        inst_v_x_d   = 1'b0;
        cx_d         = cx_q;
        inst_v_m_d   = x_to_m;
        cm_d         = cm_q;
        inst_v_r_d   = v_m_q;
        cr_d         = cr_q;
        inst_k_d     = 1'b0;
        ck_d         = ck_q;

        if (v_m_q) begin
            cr_d         = id_m_q;
            retire_cnt_d = retire_cnt_q + ID_W'(1);
        end

        if (x_to_m) begin
            id_m_d = id_x_q;
            cm_d   = id_x_q;
        end

        if (flush) begin
            v_x_d = 1'b0;
            v_i_d = 1'b0;
            if (v_i_q) begin
                inst_k_d = 1'b1;
                ck_d     = id_i_q;
            end
        end else if (!stall) begin
            v_x_d      = v_i_q;
            id_x_d     = id_i_q;
            inst_v_x_d = v_i_q;
            if (v_i_q) begin
                cx_d = id_i_q;
            end
            v_i_d = fetch_v;
            if (fetch_v) begin
                id_i_d     = nid_q;
                inst_v_i_d = 1'b1;
                ci_d       = nid_q;
                nid_d      = nid_q + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_i_q        <= 1'b0;
            id_i_q       <= '0;
            v_x_q        <= 1'b0;
            id_x_q       <= '0;
            v_m_q        <= 1'b0;
            id_m_q       <= '0;
            nid_q        <= '0;
            retire_cnt_q <= '0;
            inst_v_i_q   <= 1'b0;
            ci_q         <= '0;
            inst_v_x_q   <= 1'b0;
            cx_q         <= '0;
            inst_v_m_q   <= 1'b0;
            cm_q         <= '0;
            inst_v_r_q   <= 1'b0;
            cr_q         <= '0;
            inst_k_q     <= 1'b0;
            ck_q         <= '0;
        end else begin
            v_i_q        <= v_i_d;
            id_i_q       <= id_i_d;
            v_x_q        <= v_x_d;
            id_x_q       <= id_x_d;
            v_m_q        <= v_m_d;
            id_m_q       <= id_m_d;
            nid_q        <= nid_d;
            retire_cnt_q <= retire_cnt_d;
            inst_v_i_q   <= inst_v_i_d;
            ci_q         <= ci_d;
            inst_v_x_q   <= inst_v_x_d;
            cx_q         <= cx_d;
            inst_v_m_q   <= inst_v_m_d;
            cm_q         <= cm_d;
            inst_v_r_q   <= inst_v_r_d;
            cr_q         <= cr_d;
            inst_k_q     <= inst_k_d;
            ck_q         <= ck_d;
        end
    end

    assign inst_v_i   = inst_v_i_q;
    assign ci         = ci_q;
    assign inst_v_x   = inst_v_x_q;
    assign cx         = cx_q;
    assign inst_v_m   = inst_v_m_q;
    assign cm         = cm_q;
    assign inst_v_r   = inst_v_r_q;
    assign cr         = cr_q;
    assign inst_k     = inst_k_q;
    assign ck         = ck_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_trace_tagger.sv
// Bench for trace_tagger: a 32-bit and a 4-bit instance share stimulus and are compared
// every cycle with a slot-based reference model plus an ID-order scoreboard.
module tb_trace_tagger;

    logic clk;
    logic reset;
    logic fetch_v;
    logic stall;
    logic flush;

    logic        w_v_i, w_v_x, w_v_m, w_v_r, w_k;
    logic [31:0] w_ci, w_cx, w_cm, w_cr, w_ck, w_rcnt;
    logic        n_v_i, n_v_x, n_v_m, n_v_r, n_k;
    logic [3:0]  n_ci, n_cx, n_cm, n_cr, n_ck, n_rcnt;

    int checks = 0;
    int errors = 0;

    trace_tagger #(.ID_W(32)) u_wide (
        .clk(clk), .reset(reset), .fetch_v(fetch_v), .stall(stall), .flush(flush),
        .inst_v_i(w_v_i), .ci(w_ci), .inst_v_x(w_v_x), .cx(w_cx),
        .inst_v_m(w_v_m), .cm(w_cm), .inst_v_r(w_v_r), .cr(w_cr),
        .inst_k(w_k), .ck(w_ck), .retire_cnt(w_rcnt)
    );

    trace_tagger #(.ID_W(4)) u_narrow (
        .clk(clk), .reset(reset), .fetch_v(fetch_v), .stall(stall), .flush(flush),
        .inst_v_i(n_v_i), .ci(n_ci), .inst_v_x(n_v_x), .cx(n_cx),
        .inst_v_m(n_v_m), .cm(n_cm), .inst_v_r(n_v_r), .cr(n_cr),
        .inst_k(n_k), .ck(n_ck), .retire_cnt(n_rcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: slot 0 = I, 1 = X, 2 = M; IDs kept at 32 bits, narrow view masks them.
    logic        mv [3];
    logic [31:0] mid [3];
    logic [31:0] m_nid, m_rcnt;
    logic        e_v_i, e_v_x, e_v_m, e_v_r, e_k;
    logic [31:0] e_ci, e_cx, e_cm, e_cr, e_ck;
    logic [31:0] sb_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            mv[s]  = 1'b0;
            mid[s] = '0;
        end
        m_nid = '0; m_rcnt = '0;
        e_v_i = 0; e_v_x = 0; e_v_m = 0; e_v_r = 0; e_k = 0;
        e_ci = '0; e_cx = '0; e_cm = '0; e_cr = '0; e_ck = '0;
        sb_q.delete();
    endtask

    task automatic model_edge(input logic fv, input logic st, input logic fl);
        logic        pv [3];
        logic [31:0] pid [3];
        logic        adv;
        for (int s = 0; s < 3; s++) begin
            pv[s]  = mv[s];
            pid[s] = mid[s];
        end
        e_v_i = 0; e_v_x = 0; e_k = 0;
        e_v_r = pv[2];
        if (pv[2]) begin
            e_cr   = pid[2];
            m_rcnt = m_rcnt + 1;
        end
        adv    = pv[1] && (!st || fl);
        e_v_m  = adv;
        mv[2]  = adv;
        if (adv) begin
            mid[2] = pid[1];
            e_cm   = pid[1];
        end
        if (fl) begin
            mv[1] = 0;
            mv[0] = 0;
            if (pv[0]) begin
                e_k  = 1;
                e_ck = pid[0];
            end
        end else if (!st) begin
            mv[1]  = pv[0];
            mid[1] = pid[0];
            e_v_x  = pv[0];
            if (pv[0]) e_cx = pid[0];
            mv[0] = fv;
            if (fv) begin
                mid[0] = m_nid;
                e_v_i  = 1;
                e_ci   = m_nid;
                m_nid  = m_nid + 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("w_v_i", {31'b0, w_v_i}, {31'b0, e_v_i});
        chk("w_ci", w_ci, e_ci);
        chk("w_v_x", {31'b0, w_v_x}, {31'b0, e_v_x});
        chk("w_cx", w_cx, e_cx);
        chk("w_v_m", {31'b0, w_v_m}, {31'b0, e_v_m});
        chk("w_cm", w_cm, e_cm);
        chk("w_v_r", {31'b0, w_v_r}, {31'b0, e_v_r});
        chk("w_cr", w_cr, e_cr);
        chk("w_k", {31'b0, w_k}, {31'b0, e_k});
        chk("w_ck", w_ck, e_ck);
        chk("w_rcnt", w_rcnt, m_rcnt);
        chk("n_v_i", {31'b0, n_v_i}, {31'b0, e_v_i});
        chk("n_ci", {28'b0, n_ci}, e_ci & 32'hF);
        chk("n_v_x", {31'b0, n_v_x}, {31'b0, e_v_x});
        chk("n_cx", {28'b0, n_cx}, e_cx & 32'hF);
        chk("n_v_m", {31'b0, n_v_m}, {31'b0, e_v_m});
        chk("n_cm", {28'b0, n_cm}, e_cm & 32'hF);
        chk("n_v_r", {31'b0, n_v_r}, {31'b0, e_v_r});
        chk("n_cr", {28'b0, n_cr}, e_cr & 32'hF);
        chk("n_k", {31'b0, n_k}, {31'b0, e_k});
        chk("n_ck", {28'b0, n_ck}, e_ck & 32'hF);
        chk("n_rcnt", {28'b0, n_rcnt}, m_rcnt & 32'hF);
    endtask

    // Lifecycle order: retires come oldest-first, kills take the youngest live ID.
    task automatic scoreboard();
        if (w_v_r) begin
            chk("sb_retire_nonempty", {31'b0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) chk("sb_retire_order", w_cr, sb_q.pop_front());
        end
        if (w_k) begin
            chk("sb_kill_nonempty", {31'b0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) chk("sb_kill_id", w_ck, sb_q.pop_back());
        end
        if (w_v_i) sb_q.push_back(w_ci);
    endtask

    task automatic step(input logic fv, input logic st, input logic fl);
        fetch_v = fv;
        stall   = st;
        flush   = fl;
        @(posedge clk);
        model_edge(fv, st, fl);
        @(negedge clk);
        compare_all();
        scoreboard();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fetch_v = 0; stall = 0; flush = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Straight-line flow of three instructions
        step(1, 0, 0); chk("flow_ci0", w_ci, 32'd0);
        step(1, 0, 0); chk("flow_ci1", w_ci, 32'd1); chk("flow_cx0", w_cx, 32'd0);
        step(1, 0, 0); chk("flow_cm0", w_cm, 32'd0);
        step(0, 0, 0); chk("flow_cr0", w_cr, 32'd0);
        step(0, 0, 0);
        step(0, 0, 0); chk("flow_rcnt", w_rcnt, 32'd3);

        // Stall for two cycles with ID 1 in I and ID 0 in X
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0);
            chk("stall_no_vi", {31'b0, w_v_i}, 32'd0);
            chk("stall_no_vx", {31'b0, w_v_x}, 32'd0);
            chk("stall_no_vm", {31'b0, w_v_m}, 32'd0);
        end
        step(0, 0, 0); chk("unstall_cx", w_cx, 32'd1); chk("unstall_cm", w_cm, 32'd0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);

        // Flush with ID 4 in X and ID 5 in I, fetch ignored on the flush edge
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(1, 0, 1);
        chk("flush_k", {31'b0, w_k}, 32'd1); chk("flush_ck", w_ck, 32'd5);
        chk("flush_cm", w_cm, 32'd4);
        step(1, 0, 0); chk("flush_next_ci", w_ci, 32'd6);

        // Flush and stall together: branch 6 still moves to M, 7 is killed
        step(1, 0, 0);
        step(1, 1, 1);
        chk("fs_k", {31'b0, w_k}, 32'd1); chk("fs_ck", w_ck, 32'd7);
        chk("fs_vm", {31'b0, w_v_m}, 32'd1); chk("fs_cm", w_cm, 32'd6);
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        // Asynchronous reset with three instructions in flight
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        do_reset();
        chk("rst_rcnt", w_rcnt, 32'd0);
        step(1, 0, 0); chk("rst_ci0", w_ci, 32'd0);
        chk("rst_no_retire", {31'b0, w_v_r}, 32'd0);
        step(0, 0, 0); chk("rst_no_retire2", {31'b0, w_v_r}, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);

        // Seventeen back-to-back fetches exercise the 4-bit wrap
        do_reset();
        for (int i = 0; i < 17; i++) step(1, 0, 0);
        chk("wrap_ci", {28'b0, n_ci}, 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        chk("wrap_rcnt", {28'b0, n_rcnt}, 32'd1);
        chk("wide_rcnt17", w_rcnt, 32'd17);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 6) == 0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
